// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the calculator front-end controller:
// FSM state codes and default parameter values.
package calc_ctrl_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_EXEC  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/calc_ctrl_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter and
// rising-edge pulse of the debounced level.
module btn_debounce
  import calc_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any sample agreeing with the current level restarts the stability count.
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/calc_ctrl.sv
// Front-end controller for the accumulator calculator: debounces the buttons and
// sequences each accumulator update, keeping sticky status and an op counter.
module calc_ctrl
  import calc_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btnc,
  input  logic             btnac,
  input  logic             btnl,
  input  logic             btnr,
  input  logic             btnd,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic [2:0]       op_sel,
  output logic             acc_we,
  output logic             acc_clr,
  output logic             busy,
  output logic             ovf_flag,
  output logic             zero_flag,
  output logic [CNT_W-1:0] op_count
);

  logic [4:0] w_raw;
  logic [4:0] w_level;
  logic [4:0] w_pulse;
  logic [4:0] w_unused;
  logic       w_exe_pulse;
  logic       w_clr_pulse;

  state_t           r_state;
  logic [2:0]       r_op_sel;
  logic             r_acc_we;
  logic             r_acc_clr;
  logic             r_busy;
  logic             r_ovf;
  logic             r_zero;
  logic             r_pending_clear;
  logic [CNT_W-1:0] r_op_count;

  assign w_raw = {btnc, btnac, btnl, btnr, btnd};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_raw[i]),
      .o_level (w_level[i]),
      .o_pulse (w_pulse[i])
    );
  end

  // Select buttons are used as levels only; execute/clear only as pulses.
  assign w_unused    = {w_level[4:3], w_pulse[2:0]};
  assign w_exe_pulse = w_pulse[4];
  assign w_clr_pulse = w_pulse[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_op_sel        <= 3'b000;
      r_acc_we        <= 1'b0;
      r_acc_clr       <= 1'b0;
      r_busy          <= 1'b0;
      r_ovf           <= 1'b0;
      r_zero          <= 1'b0;
      r_pending_clear <= 1'b0;
      r_op_count      <= '0;
    end else begin
      r_acc_we  <= 1'b0;
      r_acc_clr <= 1'b0;
      if (w_clr_pulse && (r_state == S_SETUP || r_state == S_EXEC))
        r_pending_clear <= 1'b1;
      // Outputs are registered from the next state so they line up with it.
      case (r_state)
        S_IDLE: begin
          if (r_pending_clear || w_clr_pulse) begin
            r_state   <= S_CLEAR;
            r_acc_clr <= 1'b1;
            r_busy    <= 1'b1;
          end else if (w_exe_pulse) begin
            r_state  <= S_SETUP;
            r_op_sel <= w_level[2:0];
            r_busy   <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state  <= S_EXEC;
          r_acc_we <= 1'b1;
        end
        S_EXEC: begin
          r_ovf      <= r_ovf | alu_ovf;
          r_zero     <= alu_zero;
          r_op_count <= r_op_count + CNT_W'(1);
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
        end
        S_CLEAR: begin
          r_ovf           <= 1'b0;
          r_zero          <= 1'b1;
          r_op_count      <= '0;
          r_pending_clear <= 1'b0;
          r_state         <= S_IDLE;
          r_busy          <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_sel    = r_op_sel;
  assign acc_we    = r_acc_we;
  assign acc_clr   = r_acc_clr;
  assign busy      = r_busy;
  assign ovf_flag  = r_ovf;
  assign zero_flag = r_zero;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: cycle-level behavioural model compared on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_calc_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnc = 1'b0, btnac = 1'b0, btnl = 1'b0, btnr = 1'b0, btnd = 1'b0;
  logic alu_zero = 1'b0, alu_ovf = 1'b0;

  logic [2:0]    op_sel;
  logic          acc_we, acc_clr, busy, ovf_flag, zero_flag;
  logic [CW-1:0] op_count;

  calc_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .btnc(btnc), .btnac(btnac), .btnl(btnl), .btnr(btnr), .btnd(btnd),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .op_sel(op_sel), .acc_we(acc_we), .acc_clr(acc_clr), .busy(busy),
    .ovf_flag(ovf_flag), .zero_flag(zero_flag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Button index: 4=c, 3=ac, 2=l, 1=r, 0=d.
  typedef enum {M_NONE, M_EXEC, M_CLEAR} mop_t;

  bit [4:0]   m_s1, m_s2, m_lvl, m_rise;
  int         m_run [5];
  mop_t       m_op;
  int         m_step;
  bit         m_pend;
  bit         m_valid = 1'b0;
  logic [2:0] e_sel;
  bit         e_we, e_clr, e_busy, e_ovf, e_zero;
  logic [CW-1:0] e_cnt;

  always @(posedge clk) begin
    bit rc, rac, was_exec, old;
    logic [4:0] raw;
    raw = {btnc, btnac, btnl, btnr, btnd};
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      m_op = M_NONE; m_step = 0; m_pend = 1'b0;
      e_sel = '0; e_we = 0; e_clr = 0; e_busy = 0; e_ovf = 0; e_zero = 0; e_cnt = '0;
      m_valid = 1'b1;
    end else begin
      rc = m_rise[4];
      rac = m_rise[3];
      was_exec = (m_op == M_EXEC);
      e_we = 0;
      e_clr = 0;
      case (m_op)
        M_NONE:
          if (m_pend || rac) m_op = M_CLEAR;
          else if (rc) begin m_op = M_EXEC; m_step = 1; e_sel = m_lvl[2:0]; end
        M_EXEC:
          if (m_step == 1) m_step = 2;
          else begin
            e_ovf = e_ovf | alu_ovf; e_zero = alu_zero; e_cnt = e_cnt + 1'b1; m_op = M_NONE;
          end
        M_CLEAR: begin
          e_ovf = 0; e_zero = 1; e_cnt = '0; m_pend = 0; m_op = M_NONE;
        end
        default: m_op = M_NONE;
      endcase
      e_clr  = (m_op == M_CLEAR);
      e_we   = (m_op == M_EXEC) && (m_step == 2);
      if (rac && was_exec) m_pend = 1'b1;
      e_busy = (m_op != M_NONE);
      // Level follows the synchronised input once it has disagreed for DEB samples in a row.
      for (int i = 0; i < 5; i++) begin
        old = m_lvl[i];
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_lvl[i] = ~m_lvl[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
        m_rise[i] = m_lvl[i] & ~old;
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  end

  int we_seen = 0, clr_seen = 0, busy_seen = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("op_sel",    32'(op_sel),    32'(e_sel));
      check("acc_we",    32'(acc_we),    32'(e_we));
      check("acc_clr",   32'(acc_clr),   32'(e_clr));
      check("busy",      32'(busy),      32'(e_busy));
      check("ovf_flag",  32'(ovf_flag),  32'(e_ovf));
      check("zero_flag", 32'(zero_flag), 32'(e_zero));
      check("op_count",  32'(op_count),  32'(e_cnt));
      if (acc_we && acc_clr) check("we_clr_excl", 32'(1), 32'(0));
      if (acc_we)  we_seen++;
      if (acc_clr) clr_seen++;
      if (busy)    busy_seen++;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic press(input logic c, input logic ac, input int hold, input int gap);
    @(negedge clk);
    btnc = c; btnac = ac;
    repeat (hold) @(negedge clk);
    btnc = 1'b0; btnac = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  int w0, c0, b0;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_op_sel", 32'(op_sel), 32'(0));
    check("rst_busy",   32'(busy),   32'(0));
    check("rst_flags",  32'({acc_we, acc_clr, ovf_flag, zero_flag}), 32'(0));
    check("rst_count",  32'(op_count), 32'(0));
    w0 = we_seen; b0 = busy_seen;
    repeat (20) @(negedge clk);
    check("idle_busy_cycles", 32'(busy_seen - b0), 32'(0));

    // Glitch of 3 cycles must be rejected.
    w0 = we_seen; b0 = busy_seen;
    press(1'b1, 1'b0, 3, 15);
    check("glitch_we",    32'(we_seen - w0),   32'(0));
    check("glitch_busy",  32'(busy_seen - b0), 32'(0));
    check("glitch_count", 32'(op_count),       32'(0));

    // Basic execute with op 3'b100, button held 30 cycles.
    w0 = we_seen;
    @(negedge clk);
    btnl = 1'b1; btnc = 1'b1; alu_zero = 1'b0; alu_ovf = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("basic_op_sel_e7", 32'(op_sel), 32'(3'b100));
    check("basic_busy_e7",   32'(busy),   32'(1));
    check("basic_we_e7",     32'(acc_we), 32'(0));
    @(posedge clk); #1;
    check("basic_we_e8", 32'(acc_we), 32'(1));
    @(posedge clk); #1;
    check("basic_we_e9",  32'(acc_we),    32'(0));
    check("basic_count",  32'(op_count),  32'(1));
    check("basic_zero",   32'(zero_flag), 32'(0));
    repeat (22) @(negedge clk);
    btnc = 1'b0; btnl = 1'b0;
    repeat (12) @(negedge clk);
    check("basic_single_we", 32'(we_seen - w0), 32'(1));

    // Clear, then two executes with overflow, then clear again.
    c0 = clr_seen;
    press(1'b0, 1'b1, 10, 12);
    check("clr1_pulses", 32'(clr_seen - c0), 32'(1));
    check("clr1_state",  32'({ovf_flag, zero_flag, op_count}), 32'({1'b0, 1'b1, 8'd0}));
    alu_ovf = 1'b1;
    press(1'b1, 1'b0, 10, 12);
    check("ovf1_flag",  32'(ovf_flag), 32'(1));
    check("ovf1_count", 32'(op_count), 32'(1));
    alu_ovf = 1'b0; alu_zero = 1'b1;
    press(1'b1, 1'b0, 10, 12);
    check("ovf2_flag",  32'(ovf_flag),  32'(1));
    check("ovf2_zero",  32'(zero_flag), 32'(1));
    check("ovf2_count", 32'(op_count),  32'(2));
    alu_zero = 1'b0;
    c0 = clr_seen;
    press(1'b0, 1'b1, 10, 12);
    check("clr2_pulses", 32'(clr_seen - c0), 32'(1));
    check("clr2_state",  32'({ovf_flag, zero_flag, op_count}), 32'({1'b0, 1'b1, 8'd0}));

    // Simultaneous execute and clear: clear only.
    w0 = we_seen; c0 = clr_seen;
    press(1'b1, 1'b1, 10, 12);
    check("simul_we",    32'(we_seen - w0),  32'(0));
    check("simul_clr",   32'(clr_seen - c0), 32'(1));
    check("simul_count", 32'(op_count),      32'(0));

    // Clear pulse landing while the controller is in SETUP.
    @(negedge clk);
    btnc = 1'b1;
    @(negedge clk);
    btnac = 1'b1;
    repeat (7) @(posedge clk); #1;
    check("pend_we_e8", 32'(acc_we), 32'(1));
    @(posedge clk); #1;
    check("pend_count_e9", 32'(op_count), 32'(1));
    check("pend_idle_e9",  32'(busy),     32'(0));
    @(posedge clk); #1;
    check("pend_clr_e10", 32'(acc_clr), 32'(1));
    @(posedge clk); #1;
    check("pend_count_e11", 32'(op_count), 32'(0));
    repeat (15) @(negedge clk);
    btnc = 1'b0; btnac = 1'b0;
    repeat (12) @(negedge clk);

    // Randomized phase, including occasional mid-operation resets.
    repeat (300) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end
      btnc  = ($urandom_range(0, 2) == 0);
      btnac = ($urandom_range(0, 5) == 0);
      btnl  = 1'($urandom);
      btnr  = 1'($urandom);
      btnd  = 1'($urandom);
      repeat ($urandom_range(1, 12)) begin
        alu_zero = 1'($urandom);
        alu_ovf  = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    {btnc, btnac, btnl, btnr, btnd} = '0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Front-end controller for the accumulator calculator datapath.
- Debounces and synchronises the five raw push-buttons, then latches the operation select for the op encoder.
- Sequences each accumulator update through a small FSM and maintains sticky status flags and an executed-operation counter.
- Sits between the board buttons and the op-encoder/ALU/accumulator path; drives the accumulator's write and clear enables instead of the raw buttons.

Parameters:
- DEB_CYCLES, 16: consecutive stable cycles needed before a debounced button level changes (min 2).
- CNT_W, 8: width of op_count.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- btnc  in  1  raw execute button (asynchronous to clk)
- btnac  in  1  raw clear button
- btnl  in  1  raw op-select bit 2
- btnr  in  1  raw op-select bit 1
- btnd  in  1  raw op-select bit 0
- alu_zero  in  1  ALU zero flag for current operands
- alu_ovf  in  1  ALU overflow flag for current operands
- op_sel  out  3  latched {btnl,btnr,btnd} debounced levels, fed to the op encoder
- acc_we  out  1  one-cycle accumulator load enable
- acc_clr  out  1  one-cycle accumulator clear enable
- busy  out  1  high in SETUP, EXEC and CLEAR
- ovf_flag  out  1  sticky overflow since last clear
- zero_flag  out  1  zero status of last committed result
- op_count  out  CNT_W  executed operations since last clear

Behaviour:
- Reset:
  - All flops go to 0: synchronisers, debounced levels, counters, state=IDLE, pending_clear.
  - Outputs op_sel, acc_we, acc_clr, busy, ovf_flag, zero_flag and op_count are all 0.
  - Reset mid-operation aborts it; acc_we/acc_clr are low the cycle after reset and any pending clear is dropped.
- Debounce, per button:
  - 2-flop synchroniser feeding counter cnt.
  - On each edge where the synchronised value differs from the debounced value, cnt increments; otherwise cnt returns to 0.
  - When cnt reaches DEB_CYCLES-1 and the values still differ, the debounced value flips and cnt returns to 0.
  - Rising-edge pulse = debounced & ~debounced_d. Only btnc and btnac produce pulses; a held button produces exactly one pulse.
- Latency: counting from edge 1, the first edge sampling raw btnc=1 held stable:
  - Debounced level is high after edge DEB_CYCLES+2.
  - FSM enters SETUP at edge DEB_CYCLES+3 and EXEC at edge DEB_CYCLES+4.
  - acc_we is high for the following cycle, so the accumulator loads at edge DEB_CYCLES+5.
- FSM, 2-bit encoding:
  - IDLE: busy=0.
    - If pending_clear or clear pulse, go to CLEAR. Clear has priority over a simultaneous execute pulse, and that execute pulse is discarded.
    - Else if execute pulse, op_sel <= debounced {l,r,d} and go to SETUP.
  - SETUP: busy=1; op_sel held so the combinational encoder/ALU path settles; go to EXEC.
  - EXEC: acc_we=1; ovf_flag <= ovf_flag | alu_ovf; zero_flag <= alu_zero; op_count <= op_count+1, wrapping max to 0; go to IDLE.
  - CLEAR: acc_clr=1; ovf_flag <= 0; zero_flag <= 1; op_count <= 0; pending_clear <= 0; go to IDLE.
- Busy-time events:
  - Execute pulses in SETUP/EXEC/CLEAR are dropped.
  - A clear pulse in SETUP/EXEC sets pending_clear; the current op completes, and IDLE then goes to CLEAR on the next edge.
  - A clear pulse in CLEAR is dropped.
  - op_sel never changes outside the IDLE→SETUP transition.
- acc_we and acc_clr are never high in the same cycle.
- Buttons held through reset deassertion are debounced from 0 and generate one pulse.

Decomposition:
- Shared header calc_ctrl_defs.v holds the FSM state codes (IDLE=0, SETUP=1, EXEC=2, CLEAR=3) and the default DEB_CYCLES.
- One sub-module, btn_debounce (synchroniser + counter + rising-edge pulse, param DEB_CYCLES), instantiated five times.
- The FSM, flags and counter stay in calc_ctrl.

Test Plan (DEB_CYCLES=4):
- Reset: rst=1 for 2 cycles, all buttons 0 → every output 0 and state IDLE; with no stimulus for 20 cycles, everything stays 0.
- Basic execute: btnl=1, btnr=0, btnd=0 stable, btnc raised and held 30 cycles, alu_zero=0, alu_ovf=0 → op_sel=3'b100 from edge 7; acc_we high only in the cycle after edge 8; op_count=1; zero_flag=0; no second acc_we while held.
- Glitch rejection: btnc high for 3 cycles, then low → no acc_we, busy stays 0, op_count=0.
- Overflow and clear:
  - Execute with alu_ovf=1 → ovf_flag=1.
  - Second execute with alu_ovf=0 → ovf_flag stays 1, op_count=2.
  - btnac press → acc_clr for one cycle, ovf_flag=0, zero_flag=1, op_count=0.
- Simultaneous press: btnc and btnac raised on the same edge → CLEAR only; acc_we never asserted; op_count unchanged at 0.
- Clear during operation: btnac pulse lands while state=SETUP → acc_we in EXEC as normal, one IDLE cycle, then acc_clr; final op_count=0.
